// File: rtl/muldiv_ctrl.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide.
// Operands are reduced to magnitudes at capture and the sign is reapplied on
// the last iteration. Divide-by-zero and signed overflow finish without iterating.
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic         word_q, word_d;
  logic         neg_q, neg_d;     // product / quotient sign
  logic         rneg_q, rneg_d;   // remainder sign (follows dividend)
  logic [63:0]  a_q, a_d;         // multiplier, or dividend/quotient shifter
  logic [127:0] b_q, b_d;         // shifted multiplicand, or divisor
  logic [127:0] acc_q, acc_d;     // product accumulator, or partial remainder
  logic [63:0]  res_q, res_d;

  logic         handshake;
  logic         is_div, w_eff, zext, a_sgn, b_sgn, a_neg, b_neg;
  logic         div_zero, div_ovf;
  logic [63:0]  a_eff, b_eff, a_mag, b_mag, special_res;
  logic [127:0] mul_acc, step_acc, step_b, prod_s;
  logic [64:0]  rem_sh, div_rem;
  logic         div_ge;
  logic [63:0]  step_a, quo_s, rem_s, fin;

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  assign req_ready  = rst_n & (state_q == S_IDLE) & ~flush;
  assign handshake  = req_valid & req_ready;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign result     = resp_valid ? res_q : '0;

  // Decode the incoming request: effective operands, signs, magnitudes, special cases
  always_comb begin
    is_div = funct3[2];
    w_eff  = word & ((funct3 == 3'b000) | is_div);
    zext   = is_div & funct3[0];
    a_eff  = op1;
    b_eff  = op2;
    if (w_eff) begin
      a_eff = zext ? {32'd0, op1[31:0]} : sext32(op1);
      b_eff = zext ? {32'd0, op2[31:0]} : sext32(op2);
    end
    a_sgn = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) | (is_div & ~funct3[0]);
    b_sgn = (funct3 == 3'b000) | (funct3 == 3'b001) | (is_div & ~funct3[0]);
    a_neg = a_sgn & a_eff[63];
    b_neg = b_sgn & b_eff[63];
    a_mag = a_neg ? (~a_eff + 64'd1) : a_eff;
    b_mag = b_neg ? (~b_eff + 64'd1) : b_eff;
    div_zero = is_div & (b_eff == '0);
    div_ovf  = is_div & ~funct3[0] & (b_eff == '1) &
               (a_eff == (w_eff ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (div_zero) special_res = funct3[1] ? a_eff : '1;
    else          special_res = funct3[1] ? '0 : a_eff;
    if (w_eff) special_res = sext32(special_res);
  end

  // One iteration of the datapath plus final sign correction and result select
  always_comb begin
    mul_acc  = acc_q + (a_q[0] ? b_q : '0);
    rem_sh   = {acc_q[63:0], a_q[63]};
    div_ge   = (rem_sh >= {1'b0, b_q[63:0]});
    div_rem  = div_ge ? (rem_sh - {1'b0, b_q[63:0]}) : rem_sh;
    step_acc = op_q[2] ? {63'd0, div_rem} : mul_acc;
    step_a   = op_q[2] ? {a_q[62:0], div_ge} : {1'b0, a_q[63:1]};
    step_b   = op_q[2] ? b_q : {b_q[126:0], 1'b0};

    prod_s = neg_q ? (~step_acc + 128'd1) : step_acc;
    quo_s  = neg_q ? (~step_a + 64'd1) : step_a;
    rem_s  = rneg_q ? (~step_acc[63:0] + 64'd1) : step_acc[63:0];
    case (op_q)
      3'b000:                 fin = prod_s[63:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[127:64];
      3'b100, 3'b101:         fin = quo_s;
      default:                fin = rem_s;
    endcase
    if (word_q) fin = sext32(fin);
  end

  // Next-state logic: capture on handshake, iterate in CALC, hold result in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          op_d   = funct3;
          word_d = w_eff;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = w_eff ? 7'd31 : 7'd63;
          acc_d  = '0;
          if (div_zero | div_ovf) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else begin
            // Word-mode dividend is left-aligned so its bit 31 is shifted in first
            a_d     = is_div ? (w_eff ? {a_mag[31:0], 32'd0} : a_mag) : b_mag;
            b_d     = is_div ? {64'd0, b_mag} : {64'd0, a_mag};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          a_d   = step_a;
          b_d   = step_b;
          if (cnt_q == 7'd0) begin
            res_d   = fin;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency, specials, backpressure, flush, reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] op1, op2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic        busy;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  muldiv_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .word(word), .op1(op1), .op2(op2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one request; returns #1 after the handshake edge
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    funct3 = f; word = w; op1 = a; op2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Latency 1 means resp_valid is already high right after the handshake edge
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
  endtask

  task automatic run_vectors(input vec_t v[], input string grp);
    int lat;
    foreach (v[i]) begin
      issue(v[i].f, v[i].w, v[i].a, v[i].b);
      wait_resp(lat);
      asserts++;
      if (result !== v[i].exp) begin
        fails++; $display("FAIL %s/%s result: got %h expected %h", grp, v[i].name, result, v[i].exp);
      end
      asserts++;
      if (lat !== v[i].lat) begin
        fails++; $display("FAIL %s/%s latency: got %0d expected %0d", grp, v[i].name, lat, v[i].lat);
      end
      @(posedge clk); #1;
      asserts++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL %s/%s release: busy=%b resp_valid=%b req_ready=%b expected 0 0 1",
                          grp, v[i].name, busy, resp_valid, req_ready);
      end
      $display("%s %s: result=%h latency=%0d", grp, v[i].name, result, lat);
    end
  endtask

  task automatic test_reset();
    #2;
    asserts++;
    if ({req_ready, resp_valid, busy} !== 3'b000 || result !== 64'd0) begin
      fails++; $display("FAIL reset_hold: req_ready=%b resp_valid=%b busy=%b result=%h expected all 0",
                        req_ready, resp_valid, busy, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release: req_ready=%b busy=%b resp_valid=%b expected 1 0 0",
                        req_ready, busy, resp_valid);
    end
    $display("reset: req_ready=%b busy=%b", req_ready, busy);
  endtask

  task automatic test_mul();
    vec_t v[4];
    v[0] = '{"MUL_7x-3",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    v[1] = '{"MULHU_max",    3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[2] = '{"MULHSU_-1x2",  3'b010, 1'b0, '1, 64'd2, '1, 65};
    v[3] = '{"MULW_3x-2",    3'b000, 1'b1, 64'h1_0000_0003, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 33};
    run_vectors(v, "mul");
  endtask

  task automatic test_div_special();
    vec_t v[5];
    v[0] = '{"DIVU_5/0",     3'b101, 1'b0, 64'd5, 64'd0, '1, 1};
    v[1] = '{"REM_5/0",      3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    v[2] = '{"DIV_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    v[3] = '{"REM_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    v[4] = '{"REMUW_x/0",    3'b111, 1'b1, 64'h1_8000_0000, 64'h5_0000_0000, 64'hFFFF_FFFF_8000_0000, 1};
    run_vectors(v, "div_special");
  endtask

  task automatic test_div();
    vec_t v[7];
    v[0] = '{"DIVW_-7/2",    3'b100, 1'b1, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    v[1] = '{"REMW_-7/2",    3'b110, 1'b1, 64'h1_FFFF_FFF9, 64'd2, '1, 33};
    v[2] = '{"DIVUW_max/1",  3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 33};
    v[3] = '{"DIV_-100/7",   3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    v[4] = '{"REM_-100/7",   3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[5] = '{"DIVU_100/7",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    v[6] = '{"REMU_100/7",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    run_vectors(v, "div");
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    issue(3'b101, 1'b0, 64'd100, 64'd7);
    wait_resp(lat);
    asserts++;
    if (lat !== 65) begin
      fails++; $display("FAIL bp_latency: got %0d expected 65", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      asserts++;
      if (resp_valid !== 1'b1 || result !== 64'd14 || req_ready !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL bp_hold cycle %0d: resp_valid=%b result=%h req_ready=%b busy=%b expected 1 %h 0 1",
                          i, resp_valid, result, req_ready, busy, 64'd14);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 64'd0) begin
      fails++; $display("FAIL bp_release: busy=%b resp_valid=%b result=%h expected 0 0 0", busy, resp_valid, result);
    end
    $display("backpressure: held 10 cycles, released busy=%b", busy);
  endtask

  task automatic test_flush();
    logic seen;
    issue(3'b011, 1'b0, '1, '1);
    repeat (19) begin @(posedge clk); #1; end
    asserts++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL flush_pre: busy=%b resp_valid=%b expected 1 0", busy, resp_valid);
    end
    // Raised after edge T+20 so the abort lands on edge T+21
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL flush_idle: busy=%b resp_valid=%b req_ready=%b expected 0 0 0",
                        busy, resp_valid, req_ready);
    end
    // Request presented while flush is high must be dropped
    req_valid = 1'b1; funct3 = 3'b000; word = 1'b0; op1 = 64'd3; op2 = 64'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    asserts++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL flush_drop: busy=%b expected 0", busy);
    end
    flush = 1'b0;
    #1;
    asserts++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL flush_ready: req_ready=%b expected 1", req_ready);
    end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    asserts++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL flush_no_resp: resp_valid seen=%b expected 0", seen);
    end
    $display("flush: aborted at T+21, no response");
  endtask

  task automatic test_reset_midcalc();
    logic seen;
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({req_ready, resp_valid, busy} !== 3'b000 || result !== 64'd0) begin
      fails++; $display("FAIL rst_mid: req_ready=%b resp_valid=%b busy=%b result=%h expected all 0",
                        req_ready, resp_valid, busy, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_release: req_ready=%b busy=%b expected 1 0", req_ready, busy);
    end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    asserts++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rst_mid_no_resp: resp_valid seen=%b expected 0", seen);
    end
    $display("reset_midcalc: outputs cleared, no response");
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(3'b101, 1'b0, 64'd5, 64'd0);
    // Next request waits while DONE is being consumed
    funct3 = 3'b110; word = 1'b0; op1 = 64'd17; op2 = 64'd5; req_valid = 1'b1;
    asserts++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_done: resp_valid=%b req_ready=%b expected 1 0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    asserts++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_idle: busy=%b req_ready=%b expected 0 1", busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    asserts++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    wait_resp(lat);
    asserts++;
    if (result !== 64'd2 || lat !== 65) begin
      fails++; $display("FAIL b2b_second: result=%h latency=%0d expected %h 65", result, lat, 64'd2);
    end
    @(posedge clk); #1;
    $display("back_to_back: second result=%h latency=%0d", result, lat);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; funct3 = '0; word = 1'b0;
    op1 = '0; op2 = '0; flush = 1'b0; resp_ready = 1'b1;
    test_reset();
    test_mul();
    test_div_special();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_midcalc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
